control_unit_risc: RTL and testbench

- Multi-cycle FSM controller that sequences the 8-bit RISC datapath (register file R0–R3, Y/Z registers, address register, IR, PC, ALU, bus1/bus2 muxes).
- Consumes the IR contents and the zero flag.
- Drives every load, increment and mux-select control of the datapath, plus the memory write strobe.
- Fetch/decode/execute, one state per clock; memory is treated as combinational read.

---
 rtl/control_unit_risc.sv | 186 ++++++++++++++++++
 tb/tb_control_unit_risc.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/control_unit_risc.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC datapath.
// Outputs are Mealy-decoded from the current state and the IR fields.
module control_unit_risc #(
    parameter int DATAWIDTH   = 8,
    parameter int opcode_size = 4,
    parameter int sel1_size   = 3,
    parameter int sel2_size   = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] instruction,
    input  logic                 zero_flag,
    output logic                 ld_r0,
    output logic                 ld_r1,
    output logic                 ld_r2,
    output logic                 ld_r3,
    output logic                 ld_pc,
    output logic                 inc_pc,
    output logic [sel1_size-1:0] sel_bus1_mux,
    output logic [sel2_size-1:0] sel_bus2_mux,
    output logic                 ld_ir,
    output logic                 ld_address_reg,
    output logic                 ld_reg_y,
    output logic                 ld_reg_z,
    output logic                 write,
    output logic                 halted
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_FET1 = 4'd1;
    localparam logic [3:0] S_FET2 = 4'd2;
    localparam logic [3:0] S_DEC  = 4'd3;
    localparam logic [3:0] S_EX1  = 4'd4;
    localparam logic [3:0] S_RD1  = 4'd5;
    localparam logic [3:0] S_RD2  = 4'd6;
    localparam logic [3:0] S_WR1  = 4'd7;
    localparam logic [3:0] S_WR2  = 4'd8;
    localparam logic [3:0] S_BR1  = 4'd9;
    localparam logic [3:0] S_BR2  = 4'd10;
    localparam logic [3:0] S_HALT = 4'd11;

    localparam logic [opcode_size-1:0] OP_NOP = 4'd0;
    localparam logic [opcode_size-1:0] OP_ADD = 4'd1;
    localparam logic [opcode_size-1:0] OP_SUB = 4'd2;
    localparam logic [opcode_size-1:0] OP_AND = 4'd3;
    localparam logic [opcode_size-1:0] OP_NOT = 4'd4;
    localparam logic [opcode_size-1:0] OP_RD  = 4'd5;
    localparam logic [opcode_size-1:0] OP_WR  = 4'd6;
    localparam logic [opcode_size-1:0] OP_BR  = 4'd7;
    localparam logic [opcode_size-1:0] OP_BRZ = 4'd8;

    localparam logic [sel1_size-1:0] SEL1_PC  = sel1_size'(4);
    localparam logic [sel2_size-1:0] SEL2_ALU = sel2_size'(0);
    localparam logic [sel2_size-1:0] SEL2_B1  = sel2_size'(1);
    localparam logic [sel2_size-1:0] SEL2_MEM = sel2_size'(2);

    logic [3:0] state_q, state_d;
    logic [opcode_size-1:0] opcode;
    logic [1:0] src, dest;
    logic ld_dest;

    assign opcode = instruction[DATAWIDTH-1:DATAWIDTH-opcode_size];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    always_comb begin
        state_d        = state_q;
        ld_dest        = 1'b0;
        ld_pc          = 1'b0;
        inc_pc         = 1'b0;
        sel_bus1_mux   = '0;
        sel_bus2_mux   = '0;
        ld_ir          = 1'b0;
        ld_address_reg = 1'b0;
        ld_reg_y       = 1'b0;
        ld_reg_z       = 1'b0;
        write          = 1'b0;
        halted         = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                sel_bus1_mux   = SEL1_PC;
                sel_bus2_mux   = SEL2_B1;
                ld_address_reg = 1'b1;
                state_d        = S_FET2;
            end
            S_FET2: begin
                sel_bus2_mux = SEL2_MEM;
                ld_ir        = 1'b1;
                inc_pc       = 1'b1;
                state_d      = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP: state_d = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus1_mux = sel1_size'(src);
                        sel_bus2_mux = SEL2_B1;
                        ld_reg_y     = 1'b1;
                        state_d      = S_EX1;
                    end
                    OP_NOT: begin
                        sel_bus1_mux = sel1_size'(src);
                        sel_bus2_mux = SEL2_ALU;
                        ld_dest      = 1'b1;
                        ld_reg_z     = 1'b1;
                        state_d      = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        // Not-taken BRZ only steps the PC past the address byte.
                        if (opcode == OP_BRZ && !zero_flag) begin
                            inc_pc  = 1'b1;
                            state_d = S_FET1;
                        end else begin
                            sel_bus1_mux   = SEL1_PC;
                            sel_bus2_mux   = SEL2_B1;
                            ld_address_reg = 1'b1;
                            state_d        = (opcode == OP_RD) ? S_RD1 :
                                             (opcode == OP_WR) ? S_WR1 : S_BR1;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_EX1: begin
                sel_bus1_mux = sel1_size'(dest);
                sel_bus2_mux = SEL2_ALU;
                ld_dest      = 1'b1;
                ld_reg_z     = 1'b1;
                state_d      = S_FET1;
            end
            S_RD1, S_WR1: begin
                sel_bus2_mux   = SEL2_MEM;
                ld_address_reg = 1'b1;
                inc_pc         = 1'b1;
                state_d        = (state_q == S_RD1) ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                sel_bus2_mux = SEL2_MEM;
                ld_dest      = 1'b1;
                state_d      = S_FET1;
            end
            S_WR2: begin
                sel_bus1_mux = sel1_size'(src);
                write        = 1'b1;
                state_d      = S_FET1;
            end
            S_BR1: begin
                sel_bus2_mux   = SEL2_MEM;
                ld_address_reg = 1'b1;
                state_d        = S_BR2;
            end
            S_BR2: begin
                sel_bus2_mux = SEL2_MEM;
                ld_pc        = 1'b1;
                state_d      = S_FET1;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Reset masks every strobe in the same cycle it is asserted.
        if (clr) begin
            ld_dest        = 1'b0;
            ld_pc          = 1'b0;
            inc_pc         = 1'b0;
            sel_bus1_mux   = '0;
            sel_bus2_mux   = '0;
            ld_ir          = 1'b0;
            ld_address_reg = 1'b0;
            ld_reg_y       = 1'b0;
            ld_reg_z       = 1'b0;
            write          = 1'b0;
            halted         = 1'b0;
        end
    end

    assign ld_r0 = ld_dest && (dest == 2'd0);
    assign ld_r1 = ld_dest && (dest == 2'd1);
    assign ld_r2 = ld_dest && (dest == 2'd2);
    assign ld_r3 = ld_dest && (dest == 2'd3);

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end
endmodule

// File: tb/tb_control_unit_risc.sv
// Directed per-cycle vector bench for control_unit_risc: each record is one
// clock of {clr, instruction, zero_flag} with the full expected output word.
module tb_control_unit_risc;
    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] instruction;
    logic       zero_flag;
    logic ld_r0, ld_r1, ld_r2, ld_r3, ld_pc, inc_pc;
    logic [2:0] sel_bus1_mux;
    logic [1:0] sel_bus2_mux;
    logic ld_ir, ld_address_reg, ld_reg_y, ld_reg_z, write, halted;

    control_unit_risc dut (
        .clk(clk), .clr(clr), .instruction(instruction), .zero_flag(zero_flag),
        .ld_r0(ld_r0), .ld_r1(ld_r1), .ld_r2(ld_r2), .ld_r3(ld_r3),
        .ld_pc(ld_pc), .inc_pc(inc_pc),
        .sel_bus1_mux(sel_bus1_mux), .sel_bus2_mux(sel_bus2_mux),
        .ld_ir(ld_ir), .ld_address_reg(ld_address_reg),
        .ld_reg_y(ld_reg_y), .ld_reg_z(ld_reg_z),
        .write(write), .halted(halted)
    );

    always #5 clk = ~clk;

    // Packed as {r3,r2,r1,r0, ld_pc, inc_pc, sel1[2:0], sel2[1:0], ld_ir, ld_ar, ld_y, ld_z, write, halted}
    logic [16:0] act;
    assign act = {ld_r3, ld_r2, ld_r1, ld_r0, ld_pc, inc_pc, sel_bus1_mux, sel_bus2_mux,
                  ld_ir, ld_address_reg, ld_reg_y, ld_reg_z, write, halted};

    typedef struct {
        logic        clr;
        logic [7:0]  ins;
        logic        zf;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [16:0] mk(input logic [3:0] r, input logic pc, input logic inc,
                                       input logic [2:0] s1, input logic [1:0] s2,
                                       input logic ir, input logic ar, input logic y,
                                       input logic z, input logic wr, input logic h);
        return {r, pc, inc, s1, s2, ir, ar, y, z, wr, h};
    endfunction

    logic [16:0] e_zero, e_fet1, e_fet2, e_addr, e_mem1, e_halt;

    task automatic add(input logic c, input logic [7:0] ins, input logic zf,
                       input logic [16:0] exp, input string name);
        vec_t v;
        v.clr = c; v.ins = ins; v.zf = zf; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // One vector = one clock: drive after the falling edge, compare before the rising edge.
    task automatic apply(input logic c, input logic [7:0] ins, input logic zf,
                         input logic [16:0] exp, input string name);
        @(negedge clk);
        clr = c; instruction = ins; zero_flag = zf;
        #1;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [7:0] ins, input string tag);
        add(1'b0, ins, 1'b0, e_fet1, {tag, "_fet1"});
        add(1'b0, ins, 1'b0, e_fet2, {tag, "_fet2"});
    endtask

    initial begin
        clr = 1'b1; instruction = 8'h00; zero_flag = 1'b0;
        e_zero = '0;
        e_fet1 = mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        e_fet2 = mk(4'b0000, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
        e_addr = e_fet1;
        e_mem1 = mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
        e_halt = mk(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1);

        // Reset and NOP
        add(1'b1, 8'h00, 1'b0, e_zero, "reset0");
        add(1'b1, 8'h00, 1'b0, e_zero, "reset1");
        add(1'b0, 8'h00, 1'b0, e_zero, "idle");
        fetch(8'h00, "nop");
        add(1'b0, 8'h00, 1'b0, e_zero, "nop_dec");
        // ADD R1 -> R2
        fetch(8'h16, "add");
        add(1'b0, 8'h16, 1'b0, mk(4'b0000, 0, 0, 3'd1, 2'd1, 0, 0, 1, 0, 0, 0), "add_dec");
        add(1'b0, 8'h16, 1'b0, mk(4'b0100, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0), "add_ex1");
        // SUB R2 -> R3, AND R0 -> R0
        fetch(8'h2B, "sub");
        add(1'b0, 8'h2B, 1'b0, mk(4'b0000, 0, 0, 3'd2, 2'd1, 0, 0, 1, 0, 0, 0), "sub_dec");
        add(1'b0, 8'h2B, 1'b0, mk(4'b1000, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0), "sub_ex1");
        fetch(8'h30, "and");
        add(1'b0, 8'h30, 1'b0, mk(4'b0000, 0, 0, 3'd0, 2'd1, 0, 0, 1, 0, 0, 0), "and_dec");
        add(1'b0, 8'h30, 1'b0, mk(4'b0001, 0, 0, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0), "and_ex1");
        // RD -> R3
        fetch(8'h53, "rd");
        add(1'b0, 8'h53, 1'b0, e_addr, "rd_dec");
        add(1'b0, 8'h53, 1'b0, e_mem1, "rd_rd1");
        add(1'b0, 8'h53, 1'b0, mk(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "rd_rd2");
        // WR from R1
        fetch(8'h64, "wr");
        add(1'b0, 8'h64, 1'b0, e_addr, "wr_dec");
        add(1'b0, 8'h64, 1'b0, e_mem1, "wr_wr1");
        add(1'b0, 8'h64, 1'b0, mk(4'b0000, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 1, 0), "wr_wr2");
        // BRZ not taken, BRZ taken, BR
        fetch(8'h80, "brz_nt");
        add(1'b0, 8'h80, 1'b0, mk(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0), "brz_nt_dec");
        fetch(8'h80, "brz_t");
        add(1'b0, 8'h80, 1'b1, e_addr, "brz_t_dec");
        add(1'b0, 8'h80, 1'b0, mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "brz_t_br1");
        add(1'b0, 8'h80, 1'b0, mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "brz_t_br2");
        fetch(8'h70, "br");
        add(1'b0, 8'h70, 1'b0, e_addr, "br_dec");
        add(1'b0, 8'h70, 1'b0, mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0), "br_br1");
        add(1'b0, 8'h70, 1'b0, mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0), "br_br2");
        // NOT R3 -> R2
        fetch(8'h4E, "not");
        add(1'b0, 8'h4E, 1'b0, mk(4'b0100, 0, 0, 3'd3, 2'd0, 0, 0, 0, 1, 0, 0), "not_dec");
        // Illegal opcode into halt
        fetch(8'hF0, "ill");
        add(1'b0, 8'hF0, 1'b0, e_zero, "ill_dec");

        foreach (vecs[i]) apply(vecs[i].clr, vecs[i].ins, vecs[i].zf, vecs[i].exp, vecs[i].name);

        // Halt is sticky regardless of instruction and flag
        for (int i = 0; i < 12; i++)
            apply(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), e_halt, "halt_hold");
        apply(1'b1, 8'h00, 1'b0, e_zero, "halt_clr");
        apply(1'b0, 8'h00, 1'b0, e_zero, "halt_idle");
        apply(1'b0, 8'h00, 1'b0, e_fet1, "halt_refet1");

        // Lowest illegal opcode also halts
        apply(1'b0, 8'h90, 1'b0, e_fet2, "ill9_fet2");
        apply(1'b0, 8'h90, 1'b1, e_zero, "ill9_dec");
        apply(1'b0, 8'h90, 1'b0, e_halt, "ill9_halt");
        apply(1'b1, 8'h90, 1'b0, e_zero, "ill9_clr");

        // Reset in the middle of an ALU instruction
        apply(1'b0, 8'h16, 1'b0, e_zero, "mid_idle");
        apply(1'b0, 8'h16, 1'b0, e_fet1, "mid_fet1");
        apply(1'b0, 8'h16, 1'b0, e_fet2, "mid_fet2");
        apply(1'b0, 8'h16, 1'b0, mk(4'b0000, 0, 0, 3'd1, 2'd1, 0, 0, 1, 0, 0, 0), "mid_dec");
        apply(1'b1, 8'h16, 1'b0, e_zero, "mid_ex1_clr");
        apply(1'b0, 8'h16, 1'b0, e_zero, "mid_idle2");
        apply(1'b0, 8'h16, 1'b0, e_fet1, "mid_refet1");
        apply(1'b0, 8'h16, 1'b0, e_fet2, "mid_refet2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
